// File: rtl/cache_ctrl_2way_if.sv
`default_nettype none
// ============================================================================
//  Module      : cache_ctrl_2way_if
//  Description : CPU read port and memory block-fetch port bundle for the
//                2-way set-associative read cache controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cache_ctrl_2way_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int BLOCK_SIZE_BIT = 128,
    parameter int WORD_BIT       = 32
);
    // CPU side
    logic                      cpu_req_valid;
    logic [ADDR_WIDTH-1:0]     cpu_req_addr;
    logic                      cpu_req_ready;
    logic                      cpu_resp_valid;
    logic [WORD_BIT-1:0]       cpu_resp_data;
    // Memory side
    logic                      mem_req_valid;
    logic [ADDR_WIDTH-1:0]     mem_req_addr;
    logic                      mem_req_ready;
    logic                      mem_resp_valid;
    logic [BLOCK_SIZE_BIT-1:0] mem_resp_data;
    // Control / status
    logic                      flush;
    logic [15:0]               hit_cnt;
    logic [15:0]               miss_cnt;

    // Environment view: drives CPU requests, memory responses and flush
    modport master (
        output cpu_req_valid, cpu_req_addr, mem_req_ready, mem_resp_valid,
               mem_resp_data, flush,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_data, mem_req_valid,
               mem_req_addr, hit_cnt, miss_cnt
    );

    // Controller view
    modport slave (
        input  cpu_req_valid, cpu_req_addr, mem_req_ready, mem_resp_valid,
               mem_resp_data, flush,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_data, mem_req_valid,
               mem_req_addr, hit_cnt, miss_cnt
    );
endinterface
`default_nettype wire

// File: rtl/cache_ctrl_2way.sv
`default_nettype none
// ============================================================================
//  Module      : cache_ctrl_2way
//  Description : 2-way set-associative read-only cache controller. Owns tag,
//                valid, LRU and data arrays; sequences lookup, miss refill
//                and set-by-set flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_ctrl_2way #(
    parameter int ADDR_WIDTH     = 32,
    parameter int INDEX_BITS     = 4,
    parameter int BLOCK_SIZE_BIT = 128,
    parameter int WORD_BIT       = 32
) (
    input  wire logic          clk,
    input  wire logic          reset,
    cache_ctrl_2way_if.slave   bus
);
    localparam int SETS     = 2 ** INDEX_BITS;
    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 4;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOOKUP    = 3'd1;
    localparam logic [2:0] S_MISS_REQ  = 3'd2;
    localparam logic [2:0] S_MISS_WAIT = 3'd3;
    localparam logic [2:0] S_FLUSH     = 3'd4;

    // Control state
    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  victim_q, victim_d;
    logic [INDEX_BITS-1:0] flush_cnt_q, flush_cnt_d;
    logic [SETS-1:0]       valid0_q, valid0_d;
    logic [SETS-1:0]       valid1_q, valid1_d;
    logic [SETS-1:0]       lru_q, lru_d;          // names the way to evict next
    logic                  resp_valid_q, resp_valid_d;
    logic [WORD_BIT-1:0]   resp_data_q, resp_data_d;
    logic                  mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_WIDTH-1:0] mem_req_addr_q, mem_req_addr_d;
    logic [15:0]           hit_cnt_q, hit_cnt_d;
    logic [15:0]           miss_cnt_q, miss_cnt_d;

    // Storage arrays (not reset; qualified by the valid bits)
    logic [TAG_BITS-1:0]       tag0_q  [SETS];
    logic [TAG_BITS-1:0]       tag1_q  [SETS];
    logic [BLOCK_SIZE_BIT-1:0] data0_q [SETS];
    logic [BLOCK_SIZE_BIT-1:0] data1_q [SETS];

    // Decoded fields of the latched request
    logic [TAG_BITS-1:0]   w_tag;
    logic [INDEX_BITS-1:0] w_index;
    logic [1:0]            w_offset;
    logic                  w_hit0;
    logic                  w_hit1;
    logic                  w_victim;
    logic                  w_ready;
    logic                  w_fill;
    logic                  w_unused;

    assign w_tag    = addr_q[ADDR_WIDTH-1 -: TAG_BITS];
    assign w_index  = addr_q[INDEX_BITS+3:4];
    assign w_offset = addr_q[3:2];
    assign w_unused = ^addr_q[1:0];   // byte-within-word bits carry no meaning

    assign w_hit0   = valid0_q[w_index] && (tag0_q[w_index] == w_tag);
    assign w_hit1   = valid1_q[w_index] && (tag1_q[w_index] == w_tag);
    // First invalid way wins, otherwise the LRU way
    assign w_victim = !valid0_q[w_index] ? 1'b0 :
                      !valid1_q[w_index] ? 1'b1 : lru_q[w_index];

    assign w_ready  = (state_q == S_IDLE) && !bus.flush && !reset;
    assign w_fill   = (state_q == S_MISS_WAIT) && bus.mem_resp_valid && !reset;

    assign bus.cpu_req_ready  = w_ready;
    assign bus.cpu_resp_valid = resp_valid_q;
    assign bus.cpu_resp_data  = resp_data_q;
    assign bus.mem_req_valid  = mem_req_valid_q;
    assign bus.mem_req_addr   = mem_req_addr_q;
    assign bus.hit_cnt        = hit_cnt_q;
    assign bus.miss_cnt       = miss_cnt_q;

    function automatic logic [WORD_BIT-1:0] sel_word(
        input logic [BLOCK_SIZE_BIT-1:0] blk,
        input logic [1:0]                off
    );
        logic [WORD_BIT-1:0] w;
        w = blk[WORD_BIT-1:0];
        case (off)
            2'd1:    w = blk[1*WORD_BIT +: WORD_BIT];
            2'd2:    w = blk[2*WORD_BIT +: WORD_BIT];
            2'd3:    w = blk[3*WORD_BIT +: WORD_BIT];
            default: w = blk[WORD_BIT-1:0];
        endcase
        return w;
    endfunction

    // Next-state logic for the controller FSM and its bookkeeping
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        victim_d        = victim_q;
        flush_cnt_d     = flush_cnt_q;
        valid0_d        = valid0_q;
        valid1_d        = valid1_q;
        lru_d           = lru_q;
        resp_valid_d    = 1'b0;
        resp_data_d     = resp_data_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_addr_d  = mem_req_addr_q;
        hit_cnt_d       = hit_cnt_q;
        miss_cnt_d      = miss_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.flush) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = '0;
                end else if (bus.cpu_req_valid && w_ready) begin
                    addr_d  = bus.cpu_req_addr;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (w_hit0 || w_hit1) begin
                    // Way 0 takes priority if both ways ever match
                    resp_data_d    = w_hit0 ? sel_word(data0_q[w_index], w_offset)
                                            : sel_word(data1_q[w_index], w_offset);
                    resp_valid_d   = 1'b1;
                    lru_d[w_index] = w_hit0;
                    hit_cnt_d      = hit_cnt_q + 16'd1;
                    state_d        = S_IDLE;
                end else begin
                    victim_d        = w_victim;
                    miss_cnt_d      = miss_cnt_q + 16'd1;
                    mem_req_valid_d = 1'b1;
                    mem_req_addr_d  = {w_tag, w_index, 4'b0000};
                    state_d         = S_MISS_REQ;
                end
            end
            S_MISS_REQ: begin
                if (bus.mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    state_d         = S_MISS_WAIT;
                end
            end
            S_MISS_WAIT: begin
                if (bus.mem_resp_valid) begin
                    if (victim_q) valid1_d[w_index] = 1'b1;
                    else          valid0_d[w_index] = 1'b1;
                    lru_d[w_index] = ~victim_q;
                    resp_data_d    = sel_word(bus.mem_resp_data, w_offset);
                    resp_valid_d   = 1'b1;
                    state_d        = S_IDLE;
                end
            end
            S_FLUSH: begin
                valid0_d[flush_cnt_q] = 1'b0;
                valid1_d[flush_cnt_q] = 1'b0;
                lru_d[flush_cnt_q]    = 1'b0;
                if (flush_cnt_q == INDEX_BITS'(SETS - 1)) state_d = S_IDLE;
                else flush_cnt_d = flush_cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and status registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            victim_q        <= 1'b0;
            flush_cnt_q     <= '0;
            valid0_q        <= '0;
            valid1_q        <= '0;
            lru_q           <= '0;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            hit_cnt_q       <= '0;
            miss_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            victim_q        <= victim_d;
            flush_cnt_q     <= flush_cnt_d;
            valid0_q        <= valid0_d;
            valid1_q        <= valid1_d;
            lru_q           <= lru_d;
            resp_valid_q    <= resp_valid_d;
            resp_data_q     <= resp_data_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
            hit_cnt_q       <= hit_cnt_d;
            miss_cnt_q      <= miss_cnt_d;
        end
    end

    // Refill write of the victim way's tag and data
    always_ff @(posedge clk) begin
        if (w_fill) begin
            if (victim_q) begin
                tag1_q[w_index]  <= w_tag;
                data1_q[w_index] <= bus.mem_resp_data;
            end else begin
                tag0_q[w_index]  <= w_tag;
                data0_q[w_index] <= bus.mem_resp_data;
            end
        end
    end
endmodule
`default_nettype wire
